// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared fixed-point definitions for the CNN datapath stages (MAC neuron,
// sigmoid, later conv/pooling stages).
//   - CNN_DATA_WIDTH / CNN_FRAC_BITS : default signed Qm.f format
//   - fixed_t                         : signed fixed-point word
//   - FIX_MAX / FIX_MIN / FIX_ONE     : format limits and the value 1.0
//   - mac_state_e                     : neuron MAC frame FSM states
//   - sat_fixed()                     : clamp a wide accumulator to fixed_t
// No ports (package).
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 32;
    localparam int CNN_FRAC_BITS  = 16;

    // Widest accumulator sat_fixed() accepts; callers sign-extend into it.
    localparam int CNN_ACC_MAX    = 128;

    typedef logic signed [CNN_DATA_WIDTH-1:0] fixed_t;
    typedef logic signed [CNN_ACC_MAX-1:0]    acc_max_t;

    localparam fixed_t FIX_MAX = {1'b0, {(CNN_DATA_WIDTH-1){1'b1}}};
    localparam fixed_t FIX_MIN = {1'b1, {(CNN_DATA_WIDTH-1){1'b0}}};
    localparam fixed_t FIX_ONE = fixed_t'({1'b1, {CNN_FRAC_BITS{1'b0}}});

    // Sized base type keeps the encoding fixed for legacy consumers.
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } mac_state_e;

    typedef struct packed {
        fixed_t data;
        logic   sat;
    } sat_res_t;

    // Clamp a sign-extended accumulator into the fixed_t range.
    function automatic sat_res_t sat_fixed(input acc_max_t acc);
        sat_res_t r;
        if (acc > acc_max_t'(FIX_MAX)) begin
            r.data = FIX_MAX;
            r.sat  = 1'b1;
        end else if (acc < acc_max_t'(FIX_MIN)) begin
            r.data = FIX_MIN;
            r.sat  = 1'b1;
        end else begin
            r.data = acc[CNN_DATA_WIDTH-1:0];
            r.sat  = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/fx_mul_shift.sv
// -----------------------------------------------------------------------------
// fx_mul_shift
// Registered full-precision signed fixed-point multiply followed by a
// combinational rescale (arithmetic shift right by FRAC_BITS) and
// sign-extension to OUT_WIDTH. Reusable by any Qm.f datapath stage.
//
// Build option: NEURON_MAC_ROUND_EN
//   defined   -> add 2^(FRAC_BITS-1) before the shift (round half up)
//   undefined -> plain arithmetic shift (truncate toward -inf)
//
// Ports:
//   clk, rst_n  clock / async active-low reset
//   valid_i     operands present; product register loads only then
//   a_i, b_i    signed DATA_WIDTH operands
//   valid_o     product register holds a fresh product this cycle
//   res_o       rescaled product, OUT_WIDTH bits, derived from the register
// -----------------------------------------------------------------------------
module fx_mul_shift #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,   // must be >= 1
    parameter int OUT_WIDTH  = 56
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         valid_i,
    input  logic signed [DATA_WIDTH-1:0] a_i,
    input  logic signed [DATA_WIDTH-1:0] b_i,
    output logic                         valid_o,
    output logic signed [OUT_WIDTH-1:0]  res_o
);

    localparam int PW = 2 * DATA_WIDTH;      // full product width
    localparam int SW = PW + 1 - FRAC_BITS;  // significant bits after shift

    logic signed [PW-1:0] prod_d;
    logic signed [PW-1:0] prod_q;
    logic                 valid_q;
    logic        [PW:0]   prod_x;            // one guard bit for rounding
    logic                 unused_lsbs;

    assign prod_d = PW'(a_i) * PW'(b_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                prod_q <= prod_d;
            end
        end
    end

`ifdef NEURON_MAC_ROUND_EN
    localparam logic [PW:0] RND_HALF = (PW+1)'(1) << (FRAC_BITS - 1);
    // Cannot overflow: |a*b| <= 2^(PW-2), far below the guard-bit headroom.
    assign prod_x = {prod_q[PW-1], prod_q} + RND_HALF;
`else
    assign prod_x = {prod_q[PW-1], prod_q};
`endif

    // Dropping the low FRAC_BITS of the sign-extended product is the
    // arithmetic shift; the remaining slice is re-extended to OUT_WIDTH.
    generate
        if (OUT_WIDTH > SW) begin : g_ext
            assign res_o = {{(OUT_WIDTH-SW){prod_x[PW]}}, prod_x[PW:FRAC_BITS]};
        end else begin : g_trunc
            assign res_o = prod_x[FRAC_BITS +: OUT_WIDTH];
        end
    endgenerate

    assign unused_lsbs = ^prod_x[FRAC_BITS-1:0];
    assign valid_o     = valid_q;

endmodule

// File: rtl/neuron_mac.sv
// -----------------------------------------------------------------------------
// neuron_mac
// Fixed-point MAC neuron: per frame of N_INPUTS (activation, weight) pairs
// computes bias + sum(x*w) in signed Qm.f, saturates to DATA_WIDTH and emits
// one o_valid strobe. Feeds the sigmoid stage directly (no backpressure).
//
// Build option: NEURON_MAC_ROUND_EN (forwarded to fx_mul_shift) selects
// round-half-up instead of truncation when rescaling each product.
//
// Pipeline:  edge e   : pair sampled, product registered (fx_mul_shift)
//            edge e+1 : rescaled product added into the accumulator
//            edge e+2 : saturated result + o_valid registered (last pair)
//
// Ports:
//   clk, rst_n  clock / async active-low reset
//   i_valid     pair present; every valid cycle is accepted
//   i_data      activation, signed Qm.f
//   i_weight    weight, signed Qm.f
//   i_bias      bias, sampled only with the first pair of a frame
//   o_valid     one-cycle result strobe
//   o_data      saturated result, held between strobes
//   o_sat       result was clipped, held with o_data
//   o_busy      a frame is partially accepted
//
// DATA_WIDTH/FRAC_BITS must match the cnn_pkg fixed_t format, since the
// saturation helper returns fixed_t.
// -----------------------------------------------------------------------------
module neuron_mac
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int FRAC_BITS  = CNN_FRAC_BITS,
    parameter int N_INPUTS   = 16,
    parameter int ACC_WIDTH  = 56
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [DATA_WIDTH-1:0] i_weight,
    input  logic [DATA_WIDTH-1:0] i_bias,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_sat,
    output logic                  o_busy
);

    // Counter holds 0..N_INPUTS-1; N_INPUTS==1 never leaves 0.
    localparam int CW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N_INPUTS - 1);

    // ---------------------------------------------------------------- FSM
    mac_state_e                   state_q, state_d;
    logic        [CW-1:0]         cnt_q, cnt_d;
    logic signed [DATA_WIDTH-1:0] bias_q, bias_d;
    logic                         pair_first, pair_last;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bias_d     = bias_q;
        pair_first = 1'b0;
        pair_last  = 1'b0;
        if (i_valid) begin
            pair_first = (state_q == S_IDLE);
            if (pair_first) begin
                bias_d = i_bias;
            end
            if (cnt_q == CNT_LAST) begin
                pair_last = 1'b1;
                cnt_d     = '0;
                state_d   = S_IDLE;
            end else begin
                cnt_d     = cnt_q + CW'(1);
                state_d   = S_ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bias_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bias_q  <= bias_d;
        end
    end

    // ------------------------------------------------------ stage 1: multiply
    logic                        s1_vld;
    logic                        s1_first_q, s1_last_q;
    logic signed [ACC_WIDTH-1:0] prod_sh;

    fx_mul_shift #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .OUT_WIDTH  (ACC_WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (i_valid),
        .a_i     (i_data),
        .b_i     (i_weight),
        .valid_o (s1_vld),
        .res_o   (prod_sh)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
        end else begin
            s1_first_q <= pair_first;
            s1_last_q  <= pair_last;
        end
    end

    // --------------------------------------------------- stage 2: accumulate
    // bias_q still holds this frame's bias here: even back-to-back (or with
    // N_INPUTS==1) the next frame's bias lands on the same edge that reads it.
    logic signed [ACC_WIDTH-1:0] bias_ext;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        s2_last_q, s2_last_d;

    assign bias_ext = {{(ACC_WIDTH-DATA_WIDTH){bias_q[DATA_WIDTH-1]}}, bias_q};

    always_comb begin
        acc_d     = acc_q;
        s2_last_d = s1_vld & s1_last_q;
        if (s1_vld) begin
            // First pair reseeds from the bias so frames never mix.
            acc_d = (s1_first_q ? bias_ext : acc_q) + prod_sh;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            s2_last_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            s2_last_q <= s2_last_d;
        end
    end

    // ------------------------------------------------------- stage 3: output
    sat_res_t                sat_w;
    logic                    o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0]   o_data_q, o_data_d;
    logic                    o_sat_q, o_sat_d;

    assign sat_w = sat_fixed(acc_max_t'(acc_q));

    always_comb begin
        o_valid_d = s2_last_q;
        o_data_d  = o_data_q;
        o_sat_d   = o_sat_q;
        if (s2_last_q) begin
            o_data_d = sat_w.data;
            o_sat_d  = sat_w.sat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_sat_q   <= 1'b0;
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_sat_q   <= o_sat_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_sat   = o_sat_q;
    assign o_busy  = (state_q == S_ACCUM);

endmodule

// File: tb/tb_neuron_mac.sv
// -----------------------------------------------------------------------------
// tb_neuron_mac
// Directed bench for neuron_mac with N_INPUTS=4. A monitor records every
// o_valid strobe (data, sat, cycle) into queues; each frame's expectation
// is checked against hand-computed constants including exact latency.
// -----------------------------------------------------------------------------
module tb_neuron_mac;

    localparam int DW = 32;
    localparam int N  = 4;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          i_valid  = 1'b0;
    logic [DW-1:0] i_data   = '0;
    logic [DW-1:0] i_weight = '0;
    logic [DW-1:0] i_bias   = '0;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          o_sat;
    logic          o_busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [DW-1:0] q_data[$];
    logic          q_sat[$];
    int            q_cyc[$];

    neuron_mac #(
        .DATA_WIDTH (32),
        .FRAC_BITS  (16),
        .N_INPUTS   (N),
        .ACC_WIDTH  (56)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_valid  (i_valid),
        .i_data   (i_data),
        .i_weight (i_weight),
        .i_bias   (i_bias),
        .o_valid  (o_valid),
        .o_data   (o_data),
        .o_sat    (o_sat),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // cyc at a negedge equals the number of the posedge just passed.
    always @(negedge clk) begin
        if (o_valid) begin
            q_data.push_back(o_data);
            q_sat.push_back(o_sat);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_valid  = 1'b0;
            i_data   = '0;
            i_weight = '0;
            i_bias   = '0;
        end
    endtask

    // Drives N identical pairs; bias only on the first, junk afterwards.
    // le returns the posedge number that samples the last pair.
    task automatic send_frame(input logic [DW-1:0] x, input logic [DW-1:0] w,
                              input logic [DW-1:0] b, input int gap, output int le);
        le = 0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            if (i == 0) chk("busy_frame_start", o_busy, 0);
            else        chk("busy_in_frame", o_busy, 1);
            i_valid  = 1'b1;
            i_data   = x;
            i_weight = w;
            i_bias   = (i == 0) ? b : 32'hDEAD_BEEF;
            le       = cyc + 1;
            if (i < N-1) begin
                repeat (gap) begin
                    @(negedge clk);
                    i_valid = 1'b0;
                    chk("busy_in_gap", o_busy, 1);
                end
            end
        end
    endtask

    task automatic expect_out(input string tag, input logic [DW-1:0] d,
                              input logic s, input int le);
        int t = 0;
        while (q_data.size() == 0 && t < 10) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk({tag, "_strobe"}, (q_data.size() != 0), 1);
        if (q_data.size() != 0) begin
            chk({tag, "_data"},    q_data[0], d);
            chk({tag, "_sat"},     q_sat[0],  s);
            chk({tag, "_latency"}, q_cyc[0],  le + 2);
            void'(q_data.pop_front());
            void'(q_sat.pop_front());
            void'(q_cyc.pop_front());
        end
    endtask

    task automatic run(input string tag, input logic [DW-1:0] x, input logic [DW-1:0] w,
                       input logic [DW-1:0] b, input logic [DW-1:0] d, input logic s);
        int le;
        send_frame(x, w, b, 0, le);
        idle(5);
        expect_out(tag, d, s, le);
        chk({tag, "_extra"}, q_data.size(), 0);
        chk({tag, "_hold"},  o_data, d);
    endtask

    initial begin
        int ea;
        int eb;
        repeat (3) @(negedge clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_data",  o_data,  0);
        chk("rst_sat",   o_sat,   0);
        chk("rst_busy",  o_busy,  0);
        rst_n = 1'b1;
        idle(2);

        // 1.0 * 0.5 * 4 = 2.0
        run("ones", 32'h0001_0000, 32'h0000_8000, 32'h0, 32'h0002_0000, 1'b0);
        // -1.5 * 2.0 * 4 + 1.0 = -11.0
        run("neg", 32'hFFFE_8000, 32'h0002_0000, 32'h0001_0000, 32'hFFF5_0000, 1'b0);
        // 256 * 256 * 4 far above max
        run("satpos", 32'h0100_0000, 32'h0100_0000, 32'h0, 32'h7FFF_FFFF, 1'b1);
        // 256 * -256 * 4 far below min
        run("satneg", 32'h0100_0000, 32'hFF00_0000, 32'h0, 32'h8000_0000, 1'b1);

        // A: 1.0*1.0*4 + 1.0 = 5.0 with gaps; B: 2.0*0.75*4 - 2.0 = 4.0 back-to-back
        send_frame(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 2, ea);
        send_frame(32'h0002_0000, 32'h0000_C000, 32'hFFFE_0000, 0, eb);
        idle(6);
        expect_out("b2b_a", 32'h0005_0000, 1'b0, ea);
        expect_out("b2b_b", 32'h0004_0000, 1'b0, eb);
        chk("b2b_extra", q_data.size(), 0);

        // Reset after two pairs of a huge frame
        @(negedge clk);
        i_valid = 1'b1; i_data = 32'h0100_0000; i_weight = 32'h0100_0000; i_bias = 32'h7000_0000;
        @(negedge clk);
        i_bias = 32'h0;
        @(negedge clk);
        i_valid = 1'b0;
        chk("rstmid_busy_pre", o_busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", o_valid, 0);
        chk("rstmid_data",  o_data,  0);
        chk("rstmid_sat",   o_sat,   0);
        chk("rstmid_busy",  o_busy,  0);
        idle(2);
        rst_n = 1'b1;
        idle(4);
        chk("rstmid_no_strobe", q_data.size(), 0);
        // 3.0 * -1.0 * 4 + 0.5 = -11.5
        run("after_rst", 32'h0003_0000, 32'hFFFF_0000, 32'h0000_8000, 32'hFFF4_8000, 1'b0);

`ifdef NEURON_MAC_ROUND_EN
        run("round_pos", 32'h0000_0001, 32'h0000_8000, 32'h0, 32'h0000_0004, 1'b0);
        run("round_neg", 32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 32'h0000_0000, 1'b0);
`else
        run("round_pos", 32'h0000_0001, 32'h0000_8000, 32'h0, 32'h0000_0000, 1'b0);
        // -2^-17 per pair floors to -2^-16
        run("round_neg", 32'hFFFF_FFFF, 32'h0000_8000, 32'h0, 32'hFFFF_FFFC, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", n_chk);
        $fatal(1);
    end

endmodule
